// File: rtl/mvm_pkg.sv
// Shared state encoding and default dimensions for the matrix-vector sequencer.
package mvm_pkg;

    localparam int unsigned MVM_K    = 8;
    localparam int unsigned MVM_LOGK = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_X,
        ST_COMPUTE,
        ST_OUTPUT
    } mvm_state_t;

endpackage

// File: rtl/mvm_addr_gen.sv
// Row/column counters for the COMPUTE phase: issue index k, row r, bubble and
// the delayed accumulator-clear / y-write strobes that line up with the MAC pipe.
module mvm_addr_gen
    import mvm_pkg::*;
#(
    parameter int unsigned K    = MVM_K,
    parameter int unsigned LOGK = MVM_LOGK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_run,
    output logic [LOGK-1:0] o_k,
    output logic [LOGK-1:0] o_r,
    output logic [LOGK-1:0] o_y_row,
    output logic            o_issue,
    output logic            o_clear,
    output logic            o_wr_y,
    output logic            o_last
);

    localparam logic [LOGK:0]   K_W      = (LOGK+1)'(K);
    localparam logic [LOGK-1:0] LAST_ROW = LOGK'(K-1);

    logic [LOGK:0]   r_k;
    logic [LOGK-1:0] r_r;
    logic [LOGK-1:0] r_y_row;
    logic            r_rows_done;
    logic            r_first_d;
    logic            r_bub_d1;
    logic            r_bub_d2;

    logic            w_issue;
    logic            w_bubble;

    assign w_issue  = i_run && !r_rows_done && (r_k != K_W);
    assign w_bubble = i_run && !r_rows_done && (r_k == K_W);

    // y write trails the bubble by two cycles: product register, then accumulator.
    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_k         <= '0;
            r_r         <= '0;
            r_y_row     <= '0;
            r_rows_done <= 1'b0;
            r_first_d   <= 1'b0;
            r_bub_d1    <= 1'b0;
            r_bub_d2    <= 1'b0;
        end else begin
            r_first_d <= w_issue && (r_k == '0);
            r_bub_d1  <= w_bubble;
            r_bub_d2  <= r_bub_d1;
            if (w_bubble) begin
                r_k <= '0;
                if (r_r == LAST_ROW) begin
                    r_rows_done <= 1'b1;
                end else begin
                    r_r <= r_r + 1'b1;
                end
            end else if (w_issue) begin
                r_k <= r_k + 1'b1;
            end
            if (r_bub_d2) begin
                r_y_row <= r_y_row + 1'b1;
            end
        end
    end

    assign o_k     = r_k[LOGK-1:0];
    assign o_r     = r_r;
    assign o_y_row = r_y_row;
    assign o_issue = w_issue;
    assign o_clear = r_first_d;
    assign o_wr_y  = r_bub_d2;
    assign o_last  = r_bub_d2 && (r_y_row == LAST_ROW);

endmodule

// File: rtl/mvm_sequencer.sv
// Control sequencer for a K x K matrix-vector MAC datapath: loads A and x,
// walks the rows through the MAC pipe, then streams y back out.
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int unsigned K    = MVM_K,
    parameter int unsigned LOGK = MVM_LOGK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_matrix,
    input  logic              load_vector,
    input  logic              start,
    input  logic              in_valid,
    output logic [LOGK-1:0]   addr_x,
    output logic [2*LOGK-1:0] addr_a,
    output logic [LOGK-1:0]   addr_y,
    output logic              wr_en_x,
    output logic              wr_en_a,
    output logic              wr_en_y,
    output logic              clear_acc,
    output logic              busy,
    output logic              out_valid,
    output logic              done
);

    localparam logic [2*LOGK-1:0] LAST_A = (2*LOGK)'(K*K-1);
    localparam logic [2*LOGK-1:0] LAST_X = (2*LOGK)'(K-1);

    mvm_state_t        r_state;
    mvm_state_t        w_next;
    logic [2*LOGK-1:0] r_cnt;
    logic              r_mat_loaded;
    logic              r_vec_loaded;
    logic              r_out_valid;
    logic              r_done;

    logic              w_run;
    logic [LOGK-1:0]   w_k;
    logic [LOGK-1:0]   w_r;
    logic [LOGK-1:0]   w_y_row;
    logic              w_issue;
    logic              w_clear;
    logic              w_wr_y;
    logic              w_last;

    assign w_run = (r_state == ST_COMPUTE);

    mvm_addr_gen #(
        .K    (K),
        .LOGK (LOGK)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_run   (w_run),
        .o_k     (w_k),
        .o_r     (w_r),
        .o_y_row (w_y_row),
        .o_issue (w_issue),
        .o_clear (w_clear),
        .o_wr_y  (w_wr_y),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mat_loaded <= 1'b0;
            r_vec_loaded <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((((r_state == ST_LOAD_A) || (r_state == ST_LOAD_X)) && in_valid)
                         || (r_state == ST_OUTPUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_IDLE) && (w_next == ST_LOAD_A)) begin
                r_mat_loaded <= 1'b0;
            end else if ((r_state == ST_LOAD_A) && (w_next == ST_IDLE)) begin
                r_mat_loaded <= 1'b1;
            end
            if ((r_state == ST_IDLE) && (w_next == ST_LOAD_X)) begin
                r_vec_loaded <= 1'b0;
            end else if ((r_state == ST_LOAD_X) && (w_next == ST_IDLE)) begin
                r_vec_loaded <= 1'b1;
            end

            // y memory has one cycle of read latency, so valid/done trail the address.
            r_out_valid <= (r_state == ST_OUTPUT);
            r_done      <= (r_state == ST_OUTPUT) && (r_cnt == LAST_X);
        end
    end

    always_comb begin
        w_next    = r_state;
        addr_x    = '0;
        addr_a    = '0;
        addr_y    = '0;
        wr_en_x   = 1'b0;
        wr_en_a   = 1'b0;
        wr_en_y   = 1'b0;
        clear_acc = 1'b1;
        busy      = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (load_matrix) begin
                    w_next = ST_LOAD_A;
                end else if (load_vector) begin
                    w_next = ST_LOAD_X;
                end else if (start && r_mat_loaded && r_vec_loaded) begin
                    w_next = ST_COMPUTE;
                end
            end
            ST_LOAD_A: begin
                wr_en_a = in_valid;
                addr_a  = r_cnt;
                if (in_valid && (r_cnt == LAST_A)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD_X: begin
                wr_en_x = in_valid;
                addr_x  = r_cnt[LOGK-1:0];
                if (in_valid && (r_cnt == LAST_X)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                clear_acc = w_clear;
                if (w_issue) begin
                    addr_x = w_k;
                    addr_a = {w_r, w_k};
                end
                if (w_wr_y) begin
                    wr_en_y = 1'b1;
                    addr_y  = w_y_row;
                end
                if (w_last) begin
                    w_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                addr_y = r_cnt[LOGK-1:0];
                if (r_cnt == LAST_X) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Scoreboard bench: a bench-side MAC datapath hangs off the sequencer, y = A*x
// expectations come from plain arithmetic and are checked on out_valid.
module tb_mvm_sequencer;

    localparam int K    = 8;
    localparam int LOGK = 3;
    localparam int KK   = K * K;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_matrix;
    logic              load_vector;
    logic              start;
    logic              in_valid;
    logic signed [7:0] data_in;
    logic [LOGK-1:0]   addr_x;
    logic [2*LOGK-1:0] addr_a;
    logic [LOGK-1:0]   addr_y;
    logic              wr_en_x, wr_en_a, wr_en_y, clear_acc, busy, out_valid, done;

    always #5 clk = ~clk;

    mvm_sequencer #(
        .K    (K),
        .LOGK (LOGK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .start       (start),
        .in_valid    (in_valid),
        .addr_x      (addr_x),
        .addr_a      (addr_a),
        .addr_y      (addr_y),
        .wr_en_x     (wr_en_x),
        .wr_en_a     (wr_en_a),
        .wr_en_y     (wr_en_y),
        .clear_acc   (clear_acc),
        .busy        (busy),
        .out_valid   (out_valid),
        .done        (done)
    );

    // MAC datapath: 1-cycle memory reads, product register, accumulator, y memory.
    logic signed [7:0] a_mem [KK];
    logic signed [7:0] x_mem [K];
    int                y_mem [K];
    logic signed [7:0] a_rd, x_rd;
    int                prod, acc, data_out;

    always @(posedge clk) begin
        if (wr_en_a) a_mem[addr_a] <= data_in;
        if (wr_en_x) x_mem[addr_x] <= data_in;
        a_rd     <= a_mem[addr_a];
        x_rd     <= x_mem[addr_x];
        prod     <= int'(a_rd) * int'(x_rd);
        acc      <= clear_acc ? 0 : acc + prod;
        if (wr_en_y) y_mem[addr_y] <= acc;
        data_out <= y_mem[addr_y];
    end

    typedef struct { int y; bit last; } exp_t;
    typedef enum int { RQ_IDLE_OUTS, RQ_BUSY, RQ_NWA, RQ_NWY, RQ_DRAIN } rq_kind_t;
    typedef struct { rq_kind_t kind; int val; } rq_t;

    exp_t sb [$];
    rq_t  rq [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_wr_a = 0, n_wr_x = 0, n_wr_y = 0, y_seq = 0, last_y_cyc = 0;

    int  ref_A [KK];
    int  ref_x [K];
    int  stage_A [KK];
    int  stage_x [K];
    bit  ref_mat_ok = 0, ref_vec_ok = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        rq_t         r;
        logic [18:0] outs;
        cyc++;
        if (!reset) begin
            if (wr_en_a) begin
                check("addr_a order", int'(addr_a), n_wr_a % KK);
                n_wr_a++;
            end
            if (wr_en_x) begin
                check("addr_x order", int'(addr_x), n_wr_x % K);
                n_wr_x++;
            end
            if (!busy) y_seq = 0;
            if (wr_en_y) begin
                check("wr_en_y addr_y", int'(addr_y), y_seq);
                if (y_seq > 0) check("wr_en_y spacing", cyc - last_y_cyc, K + 1);
                last_y_cyc = cyc;
                y_seq++;
                n_wr_y++;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("out_valid with nothing expected", int'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", data_out, e.y);
                    check("done alignment", int'(done), int'(e.last));
                end
            end else if (done) begin
                check("done without out_valid", int'(done), 0);
            end
        end
        while (rq.size() > 0) begin
            r = rq.pop_front();
            case (r.kind)
                RQ_IDLE_OUTS: begin
                    outs = {busy, out_valid, done, wr_en_a, wr_en_x, wr_en_y, clear_acc,
                            addr_x, addr_a, addr_y};
                    check("idle/reset outputs", int'(outs), 1 << 12);
                end
                RQ_BUSY:  check("busy", int'(busy), r.val);
                RQ_NWA:   check("wr_en_a pulse count", n_wr_a, r.val);
                RQ_NWY:   check("wr_en_y pulse count", n_wr_y, r.val);
                RQ_DRAIN: check("results drained in time", sb.size(), 0);
                default:  ;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input rq_kind_t kind, input int val);
        rq_t t;
        t.kind = kind;
        t.val  = val;
        rq.push_back(t);
    endtask

    function automatic bit gap_now(input int mode, input int slot);
        if (mode == 1) return (slot % 3) == 2;
        if (mode == 2) return $urandom_range(0, 3) == 0;
        return 1'b0;
    endfunction

    task automatic load_mat(input int mode, input bit with_start);
        int i = 0;
        int s = 0;
        load_matrix = 1'b1;
        start       = with_start;
        tick();
        load_matrix = 1'b0;
        start       = 1'b0;
        while (i < KK) begin
            if (gap_now(mode, s)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                data_in  = 8'(stage_A[i]);
                i++;
            end
            s++;
            tick();
        end
        in_valid   = 1'b0;
        ref_A      = stage_A;
        ref_mat_ok = 1'b1;
    endtask

    task automatic load_vec(input int mode);
        int i = 0;
        int s = 0;
        load_vector = 1'b1;
        tick();
        load_vector = 1'b0;
        while (i < K) begin
            if (gap_now(mode, s)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                data_in  = 8'(stage_x[i]);
                i++;
            end
            s++;
            tick();
        end
        in_valid   = 1'b0;
        ref_x      = stage_x;
        ref_vec_ok = 1'b1;
    endtask

    // Accepted start: expected y rows go to the scoreboard; optionally pokes
    // load_matrix and data beats mid-run, which must change nothing.
    task automatic run_compute(input bit disturb);
        exp_t e;
        int   n = 0;
        int   a0;
        start = 1'b1;
        tick();
        start = 1'b0;
        req(RQ_BUSY, 1);
        for (int r = 0; r < K; r++) begin
            e.y = 0;
            for (int k = 0; k < K; k++) e.y += ref_A[r*K + k] * ref_x[k];
            e.last = (r == K - 1);
            sb.push_back(e);
        end
        if (disturb) begin
            a0 = n_wr_a;
            repeat (5) tick();
            load_matrix = 1'b1;
            in_valid    = 1'b1;
            data_in     = 8'sd55;
            tick();
            load_matrix = 1'b0;
            repeat (4) tick();
            in_valid = 1'b0;
            req(RQ_NWA, a0);
        end
        while (sb.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        req(RQ_DRAIN, 0);
        tick();
        sb.delete();
    endtask

    task automatic start_ignored;
        int y0 = n_wr_y;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) begin
            req(RQ_BUSY, 0);
            tick();
        end
        req(RQ_NWY, y0);
        tick();
    endtask

    task automatic rand_stage;
        for (int i = 0; i < KK; i++) stage_A[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < K; i++)  stage_x[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        reset = 1'b1; load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
        in_valid = 1'b0; data_in = '0;
        repeat (3) tick();
        req(RQ_IDLE_OUTS, 0);
        tick();
        reset = 1'b0;
        req(RQ_IDLE_OUTS, 0);
        tick();

        // Identity matrix only: start must be refused until x is loaded.
        for (int i = 0; i < KK; i++) stage_A[i] = ((i / K) == (i % K)) ? 1 : 0;
        load_mat(0, 1'b0);
        start_ignored();
        for (int i = 0; i < K; i++) stage_x[i] = i + 1;
        load_vec(0);
        run_compute(1'b0);

        // All -1 times 127, matrix loaded with every third slot idle.
        for (int i = 0; i < KK; i++) stage_A[i] = -1;
        for (int i = 0; i < K; i++)  stage_x[i] = 127;
        a0 = n_wr_a;
        load_mat(1, 1'b0);
        req(RQ_NWA, a0 + KK);
        req(RQ_BUSY, 0);
        tick();
        load_vec(1);
        run_compute(1'b0);

        // Reset 20 cycles into COMPUTE.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_mat_ok = 1'b0;
        ref_vec_ok = 1'b0;
        req(RQ_IDLE_OUTS, 0);
        tick();
        start_ignored();
        rand_stage();
        load_mat(2, 1'b0);
        start_ignored();
        load_vec(2);
        run_compute(1'b0);

        // load_matrix during COMPUTE is ignored; result unchanged.
        run_compute(1'b1);

        // load_matrix and start together in IDLE: matrix load wins.
        rand_stage();
        a0 = n_wr_a;
        load_mat(0, 1'b1);
        req(RQ_NWA, a0 + KK);
        tick();
        run_compute(1'b0);

        // Random matrices and vectors with random gaps; repeated start reuses data.
        for (int t = 0; t < 3; t++) begin
            rand_stage();
            if (t % 2 == 0) begin
                load_vec(2);
                load_mat(2, 1'b0);
            end else begin
                load_mat(2, 1'b0);
                load_vec(2);
            end
            run_compute(1'b0);
        end
        run_compute(1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_sequencer.md
MVM_SEQUENCER -- requirements
Module: mvm_sequencer

Interface
REQ-001 SHALL have parameter K, default 8, matrix dimension (K x K matrix, K-element vectors).
REQ-002 SHALL have parameter LOGK, default 3, equal to log2(K).
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports load_matrix / load_vector / start, input, 1 each, single-cycle command strobes.
REQ-006 SHALL have port in_valid, input, 1, marks a valid data_in beat during loads.
REQ-007 SHALL have ports addr_x (LOGK), addr_a (2*LOGK), addr_y (LOGK), output, memory addresses.
REQ-008 SHALL have ports wr_en_x, wr_en_a, wr_en_y, clear_acc, output, 1 each, datapath controls.
REQ-009 SHALL have ports busy, out_valid, done, output, 1 each, status signals.

Function
REQ-010 SHALL implement states IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
REQ-011 SHALL accept commands only in IDLE; commands in any other state are ignored.
REQ-012 SHALL resolve simultaneous commands with priority load_matrix > load_vector > start.
REQ-013 LOAD_A SHALL drive wr_en_a = in_valid and addr_a = beat count; it SHALL return to IDLE in the cycle after the K*K-th valid beat and set matrix_loaded.
REQ-014 LOAD_X SHALL behave as REQ-013 with K beats, addr_x and wr_en_x, and SHALL set vector_loaded.
REQ-015 Gaps in in_valid SHALL stall the beat count without error.
REQ-016 Entering LOAD_A SHALL clear matrix_loaded; entering LOAD_X SHALL clear vector_loaded.
REQ-017 start SHALL be ignored unless both loaded flags are set.
REQ-018 COMPUTE row r (0..K-1) SHALL issue addr_x = k and addr_a = K*r + k for k = 0..K-1 in consecutive cycles from issue cycle c0.
REQ-019 Row period SHALL be K+1 cycles, with one bubble cycle after the last issue.
REQ-020 clear_acc SHALL be high in cycle c0+1 of each row and low during the rest of COMPUTE.
REQ-021 wr_en_y SHALL pulse in cycle c0+K+2 with addr_y = r; this pulse accounts for 1-cycle memory read latency, 1 product register, 1 accumulator register.
REQ-022 COMPUTE SHALL last exactly K*(K+1)+2 cycles, then enter OUTPUT.
REQ-023 OUTPUT SHALL drive addr_y = 0..K-1 over K cycles, then return to IDLE.
REQ-024 out_valid SHALL be high in the cycle after each OUTPUT address, for K consecutive cycles.
REQ-025 done SHALL pulse for 1 cycle coincident with the last out_valid.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 Loaded flags SHALL persist across computations, so repeated start reuses the stored A and x.
REQ-028 Outside their active phases, the write enables SHALL be 0, clear_acc SHALL be 1, and the addresses SHALL be 0.

Reset
REQ-029 reset SHALL dominate all commands.
REQ-030 On reset the block SHALL enter IDLE and clear all counters and both loaded flags.
REQ-031 On reset the outputs SHALL be: busy = out_valid = done = 0, wr_en_* = 0, clear_acc = 1, addresses = 0.
REQ-032 Reset asserted mid-operation SHALL take effect at the next clock edge, with no further writes issued.

Structure
REQ-033 Package mvm_pkg SHALL hold the state enum and the default K/LOGK constants.
REQ-034 Sub-module mvm_addr_gen SHALL hold the row/column counters producing the k, r, and bubble indices.
REQ-035 The sequencer SHALL connect to the existing MAC datapath without modifying it.

Verification
REQ-036 A = identity, x = 1..8, start -> y = 1,2,...,8 on data_out across 8 out_valid cycles; done coincides with y[7].
REQ-037 All A = -1, all x = 127 -> every y = -1016; wr_en_y pulses exactly 9 cycles apart.
REQ-038 start with only the matrix loaded -> busy stays 0 and no wr_en_y pulse occurs.
REQ-039 Load the matrix with in_valid gaps (every third beat low) -> exactly 64 wr_en_a pulses at addresses 0..63, then IDLE.
REQ-040 reset asserted 20 cycles into COMPUTE -> next cycle shows IDLE and the REQ-031 outputs; a following start is ignored until both A and x are reloaded.
REQ-041 load_matrix pulsed during COMPUTE -> ignored and y results unchanged; load_matrix and start in the same IDLE cycle -> LOAD_A entered.
